cook_sequencer: RTL and testbench
=================================

# cook_sequencer

Cooking-cycle controller for the microwave oven. It owns the BCD cook time and enters it digit by digit from the keypad. It derives the 1 Hz tick from `clk`, counts the time down, and duty-cycles the magnetron according to a power level. It also enforces the door interlock and the start/stop/clear button semantics. It sits between the keypad/buttons and the 7-segment decoders, and replaces the free-running timer/magnetron pairing with a single sequenced state machine.

## Interface
- `CLK_DIV`, default 1000: `clk` cycles per 1 s tick (≥2).
- `BEEP_TICKS`, default 3: ticks `beep` stays high in DONE.
- `clk` input, 1 bit: system clock, rising edge.
- `resetn` input, 1 bit: one clock; reset is asynchronous and active-low.
- `key_valid` input, 1 bit: one-cycle strobe, `key_digit` valid.
- `key_digit` input, 4 bits: entered digit 0–9; values 10–15 are ignored.
- `power` input, 4 bits: power level, latched at each start; 0 or >10 is treated as 10.
- `startn`, `stopn`, `clearn` input, 1 bit each: active-low buttons, synchronous to `clk`.
- `door_closed` input, 1 bit: 1 = door shut.
- `mins`, `sec_tens`, `sec_ones` output, 4 bits each: BCD time to the decoders.
- `mag_on` output, 1 bit: magnetron enable.
- `beep` output, 1 bit: end-of-cook indicator.
- `state` output, 3 bits: IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.

## Operation
- Reset state: IDLE, time 0:00, `mag_on`=0, `beep`=0, prescaler=0, window counter=0, latched power=10, button history registers=1.
- Buttons act on the falling edge only: the previous sample is 1 and the current sample is 0. A held button acts once.
- Event priority within one cycle: clear > stop > door open > start > key.
- Digit entry is accepted in IDLE and SET only. It shifts left: `mins`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←digit.
- A shift is rejected (time unchanged) when the old `sec_ones` >5, so `sec_tens` never exceeds 5. The old `mins` is discarded on a shift.
- An accepted digit moves IDLE→SET.
- Start in IDLE/SET:
  - If time ≠0:00 and `door_closed`=1 → COOK. Power is latched, and the prescaler and window counter clear.
  - Otherwise the start is ignored.
- Start in PAUSE with `door_closed`=1 → COOK. Prescaler and window counter clear; power is re-latched.
- COOK:
  - Each tick (prescaler reaching CLK_DIV−1) decrements the BCD time with borrow: `sec_ones` 0→9 borrows from `sec_tens`; `sec_tens` 0→5 borrows from `mins`.
  - A decrement that produces 0:00 → DONE.
- Power duty cycle: a 10-tick window counter runs 0..9 in COOK. The internal `mag_req` = (window count < latched power). `mag_on` = `mag_req` & `door_closed` & (state==COOK). The door term is combinational, so `mag_on` drops in the same cycle the door opens.
- Door open in COOK → PAUSE. Time is held.
- Stop in COOK → PAUSE. Stop in PAUSE → IDLE with time 0:00.
- Stop in IDLE/SET clears the time to 0:00 and returns to IDLE.
- Clear in any state → IDLE, time 0:00, `beep`=0.
- DONE:
  - `beep`=1 for BEEP_TICKS ticks, then the state returns to IDLE with time 0:00.
  - Start, stop or `key_valid` in DONE ends the beep immediately and returns to IDLE. A digit that ends DONE this way is not entered.
- The prescaler runs in COOK and DONE only, and holds at 0 in the other states.

## Timing
- All state and registered outputs update on the `clk` rising edge. Reset is asynchronous and takes effect immediately.
- Button edge latency: a falling edge is sampled at edge k, and the state change is visible after edge k.
- The first decrement occurs at edge k+CLK_DIV after the COOK entry edge k. Subsequent decrements occur every CLK_DIV cycles.
- `mag_on` is high from the cycle after the COOK entry edge when the latched power ≥1 (always, since 0 maps to 10).
- At power P the magnetron is on for P of every 10 ticks, starting from window count 0 at COOK entry and at each resume.
- Final decrement: the edge that loads 0:00 also enters DONE. `mag_on`=0 and `beep`=1 from that edge.
- Decrement and stop in the same cycle: stop wins, PAUSE, no decrement.
- Door open and tick in the same cycle: PAUSE, no decrement.
- `resetn` asserted mid-COOK: `mag_on` goes low asynchronously and all registers take their reset values.

## Test plan
- Keys 1,3,0, start, CLK_DIV=4 → time 1:30 then 1:29 after 4 cycles. After 40 cycles from start, the time reads 1:20. After 9 more ticks the time reads 1:11 and the state is still COOK. The 0:59 borrow appears after the 31st tick.
- Key 7 then key 5 → second key rejected, time stays 0:07. Then start, power=3 → `mag_on` high for 3 ticks, low for 4, then DONE at 0:00 with `beep` high for 3 ticks, then IDLE.
- Set 0:10, start, drop `door_closed` mid-cook → `mag_on`=0 in the same cycle, PAUSE, time frozen. Restore the door and press start → COOK resumes from the frozen value.
- Press start with time 0:00, or with `door_closed`=0 and time 0:05 → state unchanged, `mag_on`=0.
- In COOK, press stop → PAUSE. Press stop again → IDLE, 0:00. Separately, clear and start falling in the same cycle → IDLE, 0:00.
- Assert `resetn`=0 mid-COOK at 0:42 → `mag_on` low immediately. After release: IDLE, 0:00, `beep`=0.

Source files
------------

// File: rtl/cook_sequencer.sv
// cook_sequencer: microwave cook-cycle controller.
// Owns the BCD cook time and builds it from keypad digits. Derives a
// 1 Hz tick from clk and counts the time down during COOK. Duty-cycles
// the magnetron over a 10-tick window and enforces the door interlock
// and the start/stop/clear button semantics.
module cook_sequencer #(
  parameter int CLK_DIV    = 1000,
  parameter int BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic [3:0] power,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

  state_t        cur_state;
  state_t        next_state;
  logic [3:0]    mins_next;
  logic [3:0]    tens_next;
  logic [3:0]    ones_next;
  logic [PW-1:0] prescaler;
  logic [PW-1:0] pre_next;
  logic [3:0]    window;
  logic [3:0]    win_next;
  logic [3:0]    power_lat;
  logic [3:0]    power_next;
  logic [BW-1:0] beep_cnt;
  logic [BW-1:0] beep_cnt_next;
  logic          beep_next;
  logic          start_prev;
  logic          stop_prev;
  logic          clear_prev;

  logic          start_fall;
  logic          stop_fall;
  logic          clear_fall;
  logic          running;
  logic          tick;
  logic          mag_req;
  logic          time_nonzero;
  logic          digit_ok;
  logic [3:0]    power_eff;
  logic [3:0]    dec_mins;
  logic [3:0]    dec_tens;
  logic [3:0]    dec_ones;
  logic          dec_zero;
  logic          go_idle;

  assign state        = cur_state;
  assign start_fall   = start_prev & ~startn;
  assign stop_fall    = stop_prev & ~stopn;
  assign clear_fall   = clear_prev & ~clearn;
  assign running      = (cur_state == COOK) || (cur_state == DONE);
  assign tick         = running && (prescaler == PRE_LAST);
  assign mag_req      = (window < power_lat);
  assign mag_on       = mag_req & door_closed & (cur_state == COOK);
  assign time_nonzero = |{mins, sec_tens, sec_ones};
  assign digit_ok     = (key_digit <= 4'd9) && (sec_ones <= 4'd5);
  assign power_eff    = ((power == 4'd0) || (power > 4'd10)) ? 4'd10 : power;
  assign dec_zero     = (dec_mins == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

  // One-second BCD decrement with borrow through seconds and tens of seconds
  always_comb begin
    dec_mins = mins;
    dec_tens = sec_tens;
    dec_ones = sec_ones - 4'd1;
    if (sec_ones == 4'd0) begin
      dec_ones = 4'd9;
      if (sec_tens == 4'd0) begin
        dec_tens = 4'd5;
        dec_mins = mins - 4'd1;
      end else begin
        dec_tens = sec_tens - 4'd1;
      end
    end
  end

  // Next-state and datapath updates, events resolved clear > stop > door > start > key > tick
  always_comb begin
    next_state    = cur_state;
    mins_next     = mins;
    tens_next     = sec_tens;
    ones_next     = sec_ones;
    power_next    = power_lat;
    beep_next     = beep;
    beep_cnt_next = beep_cnt;
    go_idle       = 1'b0;
    pre_next      = tick ? '0 : prescaler + PW'(1);
    win_next      = window;
    if ((cur_state == COOK) && tick) begin
      win_next = (window == 4'd9) ? 4'd0 : window + 4'd1;
    end

    if (clear_fall) begin
      go_idle = 1'b1;
    end else if (stop_fall) begin
      if (cur_state == COOK) begin
        next_state = PAUSE;
      end else begin
        go_idle = 1'b1;
      end
    end else if ((cur_state == COOK) && !door_closed) begin
      next_state = PAUSE;
    end else if (start_fall && door_closed &&
                 ((((cur_state == IDLE) || (cur_state == SET)) && time_nonzero) ||
                  (cur_state == PAUSE))) begin
      next_state = COOK;
      power_next = power_eff;
      pre_next   = '0;
      win_next   = 4'd0;
    end else if ((start_fall || key_valid) && (cur_state == DONE)) begin
      go_idle = 1'b1;
    end else if (key_valid && ((cur_state == IDLE) || (cur_state == SET))) begin
      if (digit_ok) begin
        mins_next  = sec_tens;
        tens_next  = sec_ones;
        ones_next  = key_digit;
        next_state = SET;
      end
    end else if (tick && (cur_state == COOK)) begin
      mins_next = dec_mins;
      tens_next = dec_tens;
      ones_next = dec_ones;
      if (dec_zero) begin
        next_state    = DONE;
        beep_next     = 1'b1;
        beep_cnt_next = '0;
      end
    end else if (tick && (cur_state == DONE)) begin
      if (beep_cnt == BEEP_LAST) begin
        go_idle = 1'b1;
      end else begin
        beep_cnt_next = beep_cnt + BW'(1);
      end
    end

    if (go_idle) begin
      next_state = IDLE;
      mins_next  = 4'd0;
      tens_next  = 4'd0;
      ones_next  = 4'd0;
      beep_next  = 1'b0;
    end

    if ((next_state != COOK) && (next_state != DONE)) begin
      pre_next = '0;
    end
    if (next_state != COOK) begin
      win_next = 4'd0;
    end
  end

  // State, time, timing counters and button history registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_state  <= IDLE;
      mins       <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      prescaler  <= '0;
      window     <= 4'd0;
      power_lat  <= 4'd10;
      beep       <= 1'b0;
      beep_cnt   <= '0;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
      clear_prev <= 1'b1;
    end else begin
      cur_state  <= next_state;
      mins       <= mins_next;
      sec_tens   <= tens_next;
      sec_ones   <= ones_next;
      prescaler  <= pre_next;
      window     <= win_next;
      power_lat  <= power_next;
      beep       <= beep_next;
      beep_cnt   <= beep_cnt_next;
      start_prev <= startn;
      stop_prev  <= stopn;
      clear_prev <= clearn;
    end
  end

endmodule

// File: tb/tb_cook_sequencer.sv
// tb_cook_sequencer: directed bench for cook_sequencer with a seconds-based
// reference model compared every cycle, plus hand-computed checkpoints.
module tb_cook_sequencer;

  localparam int CLK_DIV    = 4;
  localparam int BEEP_TICKS = 3;
  localparam int S_IDLE  = 0;
  localparam int S_SET   = 1;
  localparam int S_COOK  = 2;
  localparam int S_PAUSE = 3;
  localparam int S_DONE  = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic [3:0] power = 4'd0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       clearn = 1'b1;
  logic       door_closed = 1'b1;
  logic [3:0] mins;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       mag_on;
  logic       beep;
  logic [2:0] state;

  int checks = 0;
  int fails = 0;

  // Reference model state: time kept as plain seconds
  int m_state = S_IDLE;
  int m_secs = 0;
  int m_cyc = 0;
  int m_ticks = 0;
  int m_pow = 10;
  int m_beeps = 0;
  bit m_sp = 1'b1;
  bit m_pp = 1'b1;
  bit m_cp = 1'b1;

  cook_sequencer #(.CLK_DIV(CLK_DIV), .BEEP_TICKS(BEEP_TICKS)) dut (
    .clk(clk),
    .resetn(resetn),
    .key_valid(key_valid),
    .key_digit(key_digit),
    .power(power),
    .startn(startn),
    .stopn(stopn),
    .clearn(clearn),
    .door_closed(door_closed),
    .mins(mins),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .mag_on(mag_on),
    .beep(beep),
    .state(state)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_time(input string name, input int m, input int t, input int o);
    check_output({name, "_mins"}, 32'(mins), 32'(m));
    check_output({name, "_tens"}, 32'(sec_tens), 32'(t));
    check_output({name, "_ones"}, 32'(sec_ones), 32'(o));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic apply_stimulus(input logic kv, input logic [3:0] kd, input logic sn,
                                input logic pn, input logic cn, input int n);
    key_valid = kv;
    key_digit = kd;
    startn    = sn;
    stopn     = pn;
    clearn    = cn;
    step(n);
  endtask

  task automatic press_key(input logic [3:0] d);
    apply_stimulus(1'b1, d, 1'b1, 1'b1, 1'b1, 1);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1);
  endtask

  task automatic press_start();
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1);
  endtask

  task automatic press_stop();
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1);
  endtask

  task automatic press_clear();
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1);
  endtask

  // Behavioural model: seconds arithmetic, cycle and tick counts since cook entry
  always @(posedge clk or negedge resetn) begin : model
    bit sf, pf, cf, tick, go_idle, entered;
    int o_state, d_t, d_o;
    if (!resetn) begin
      m_state = S_IDLE; m_secs = 0; m_cyc = 0; m_ticks = 0;
      m_pow = 10; m_beeps = 0; m_sp = 1'b1; m_pp = 1'b1; m_cp = 1'b1;
    end else begin
      sf = m_sp && !startn;
      pf = m_pp && !stopn;
      cf = m_cp && !clearn;
      tick = (m_state == S_COOK || m_state == S_DONE) && (m_cyc % CLK_DIV == CLK_DIV - 1);
      o_state = m_state;
      go_idle = 1'b0;
      entered = 1'b0;
      if (cf) go_idle = 1'b1;
      else if (pf) begin
        if (m_state == S_COOK) m_state = S_PAUSE; else go_idle = 1'b1;
      end
      else if (m_state == S_COOK && !door_closed) m_state = S_PAUSE;
      else if (sf && door_closed &&
               (((m_state == S_IDLE || m_state == S_SET) && m_secs != 0) || m_state == S_PAUSE)) begin
        m_state = S_COOK;
        m_pow = (power == 0 || power > 10) ? 10 : int'(power);
        entered = 1'b1;
      end
      else if ((sf || key_valid) && m_state == S_DONE) go_idle = 1'b1;
      else if (key_valid && (m_state == S_IDLE || m_state == S_SET)) begin
        d_t = (m_secs % 60) / 10;
        d_o = m_secs % 10;
        if (key_digit <= 9 && d_o <= 5) begin
          m_secs = d_t * 60 + d_o * 10 + int'(key_digit);
          m_state = S_SET;
        end
      end
      else if (tick && m_state == S_COOK) begin
        m_secs = m_secs - 1;
        m_ticks = m_ticks + 1;
        if (m_secs == 0) begin
          m_state = S_DONE;
          m_beeps = 0;
        end
      end
      else if (tick && m_state == S_DONE) begin
        m_beeps = m_beeps + 1;
        if (m_beeps == BEEP_TICKS) go_idle = 1'b1;
      end
      if (go_idle) begin
        m_state = S_IDLE;
        m_secs = 0;
      end
      if (entered) begin
        m_cyc = 0;
        m_ticks = 0;
      end else if ((o_state == S_COOK || o_state == S_DONE) && (m_state == S_COOK || m_state == S_DONE))
        m_cyc = m_cyc + 1;
      else
        m_cyc = 0;
      m_sp = startn;
      m_pp = stopn;
      m_cp = clearn;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    check_output("cyc_state", 32'(state), 32'(m_state));
    check_output("cyc_mins", 32'(mins), 32'(m_secs / 60));
    check_output("cyc_tens", 32'(sec_tens), 32'((m_secs % 60) / 10));
    check_output("cyc_ones", 32'(sec_ones), 32'(m_secs % 10));
    check_output("cyc_mag_on", 32'(mag_on),
                 32'((m_state == S_COOK) && ((m_ticks % 10) < m_pow) && door_closed));
    check_output("cyc_beep", 32'(beep), 32'(m_state == S_DONE));
  end

  // Directed scenarios with hand-computed checkpoints
  initial begin
    step(2);
    resetn = 1'b1;
    step(1);
    check_output("reset_state", 32'(state), 32'(S_IDLE));
    check_time("reset_time", 0, 0, 0);
    check_output("reset_mag", 32'(mag_on), 32'd0);
    check_output("reset_beep", 32'(beep), 32'd0);

    // 1:30 countdown at full power
    power = 4'd0;
    press_key(4'd1); press_key(4'd3); press_key(4'd0);
    check_time("entry_130", 1, 3, 0);
    press_start();
    check_output("cook_entry", 32'(state), 32'(S_COOK));
    check_time("start_130", 1, 3, 0);
    step(3);
    check_time("first_dec", 1, 2, 9);
    step(36);
    check_time("forty_cyc", 1, 2, 0);
    step(36);
    check_time("nineteen_ticks", 1, 1, 1);
    check_output("still_cook", 32'(state), 32'(S_COOK));
    step(44);
    check_time("thirty_ticks", 1, 0, 0);
    step(4);
    check_time("borrow_059", 0, 5, 9);
    press_clear();
    check_output("clear_idle", 32'(state), 32'(S_IDLE));
    check_time("clear_time", 0, 0, 0);

    // Rejected shift, power 3, done and beep
    press_key(4'd7); press_key(4'd5);
    check_time("reject_5", 0, 0, 7);
    power = 4'd3;
    press_start();
    step(10);
    check_output("p3_on", 32'(mag_on), 32'd1);
    step(1);
    check_output("p3_off", 32'(mag_on), 32'd0);
    check_time("p3_time", 0, 0, 4);
    step(16);
    check_output("done_state", 32'(state), 32'(S_DONE));
    check_output("done_beep", 32'(beep), 32'd1);
    check_time("done_time", 0, 0, 0);
    step(11);
    check_output("beep_last", 32'(beep), 32'd1);
    step(1);
    check_output("beep_end_state", 32'(state), 32'(S_IDLE));
    check_output("beep_end", 32'(beep), 32'd0);

    // Door opened mid-cook, resume, stop on a tick edge, stop again
    power = 4'd0;
    press_key(4'd1); press_key(4'd0);
    press_start();
    step(5);
    check_output("door_pre_mag", 32'(mag_on), 32'd1);
    door_closed = 1'b0;
    #1;
    check_output("door_mag_comb", 32'(mag_on), 32'd0);
    step(1);
    check_output("door_pause", 32'(state), 32'(S_PAUSE));
    check_time("door_frozen", 0, 0, 9);
    step(10);
    check_time("door_still", 0, 0, 9);
    door_closed = 1'b1;
    press_start();
    check_output("resume", 32'(state), 32'(S_COOK));
    step(3);
    check_time("resume_dec", 0, 0, 8);
    step(3);
    press_stop();
    check_output("stop_tick", 32'(state), 32'(S_PAUSE));
    check_time("stop_tick_time", 0, 0, 8);
    press_stop();
    check_output("stop2", 32'(state), 32'(S_IDLE));
    check_time("stop2_time", 0, 0, 0);

    // Ignored starts and ignored digit
    press_start();
    check_output("start_zero", 32'(state), 32'(S_IDLE));
    press_key(4'd12);
    check_output("key_12", 32'(state), 32'(S_IDLE));
    press_key(4'd5);
    door_closed = 1'b0;
    press_start();
    check_output("start_door", 32'(state), 32'(S_SET));
    check_output("start_door_mag", 32'(mag_on), 32'd0);
    door_closed = 1'b1;
    press_stop();
    check_output("stop_set", 32'(state), 32'(S_IDLE));
    check_time("stop_set_time", 0, 0, 0);

    // Clear and start together
    press_key(4'd4);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1);
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1);
    check_output("clr_start", 32'(state), 32'(S_IDLE));
    check_time("clr_start_time", 0, 0, 0);

    // Key press ends DONE without being entered
    press_key(4'd1);
    press_start();
    step(3);
    check_output("done_key_pre", 32'(state), 32'(S_DONE));
    press_key(4'd9);
    check_output("done_key", 32'(state), 32'(S_IDLE));
    check_time("done_key_time", 0, 0, 0);

    // Asynchronous reset mid-cook
    press_key(4'd4); press_key(4'd2);
    press_start();
    step(1);
    check_output("rst_pre_mag", 32'(mag_on), 32'd1);
    check_time("rst_pre_time", 0, 4, 2);
    resetn = 1'b0;
    #1;
    check_output("rst_mag", 32'(mag_on), 32'd0);
    check_output("rst_state", 32'(state), 32'(S_IDLE));
    step(1);
    resetn = 1'b1;
    step(1);
    check_output("rst_post_state", 32'(state), 32'(S_IDLE));
    check_time("rst_post_time", 0, 0, 0);
    check_output("rst_post_beep", 32'(beep), 32'd0);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
